// File: rtl/nios_handshake_dbg_mem_access.sv
// nios_handshake_dbg_mem_access
//
// Debug memory-access engine downstream of the CPU debug-slave wrapper. It decodes the
// sysclk-domain command strobes plus the 38-bit jdo payload, then runs one single-word
// Avalon-MM read or write at a time. Results go back to the wrapper's JTAG readback path.
//
// jdo layout:
//   [37]         clear monitor_error (ocimem_a only)
//   [36]         auto-increment enable (ocimem_a only)
//   [35]         issue a read after loading the address (ocimem_a only)
//   [34:3]       write data (ocimem_b)
//   [ADDR_W+1:2] word address (ocimem_a)
//
// Ports:
//   clk, reset_n             system clock, asynchronous active-low reset
//   jdo                      command payload
//   take_action_ocimem_a     load address / auto-increment, optional read
//   take_action_ocimem_b     write jdo[34:3] at the current address
//   take_no_action_ocimem_a  read at the current address
//   MonDReg                  data from the last completed read
//   monitor_ready            engine idle, last operation complete
//   monitor_error            sticky: dropped command or bus timeout
//   avm_*                    Avalon-MM master (byte address, single word, all lanes enabled)
//
// Optional build macro DBG_MEM_ACCESS_TIMEOUT_EN: when defined, an access stalled by
// avm_waitrequest for TIMEOUT_CYCLES cycles is abandoned and flagged in monitor_error.
// When undefined, an access waits on avm_waitrequest indefinitely.
//
// All outputs come straight from flops.

module nios_handshake_dbg_mem_access #(
  parameter int unsigned ADDR_W         = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  output logic [ADDR_W+1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  output logic [3:0]        avm_byteenable,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_waitrequest
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              autoinc_q, autoinc_d;
  logic [31:0]       mon_dreg_q, mon_dreg_d;
  logic              ready_q, ready_d;
  logic              error_q, error_d;
  logic              read_q, read_d;
  logic              write_q, write_d;
  logic [ADDR_W+1:0] bus_addr_q, bus_addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              any_strobe;

`ifdef DBG_MEM_ACCESS_TIMEOUT_EN
  localparam int unsigned TcntW = 10;
  // Abort on the stalled cycle that brings the stall count up to TIMEOUT_CYCLES.
  localparam logic [TcntW-1:0] TcntLast = TcntW'(TIMEOUT_CYCLES - 1);

  logic [TcntW-1:0] tcnt_q, tcnt_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

  // jdo[1:0] carry nothing for this engine.
  logic unused_jdo;
  assign unused_jdo = ^jdo[1:0];

  assign any_strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    autoinc_d  = autoinc_q;
    mon_dreg_d = mon_dreg_q;
    ready_d    = ready_q;
    error_d    = error_q;
    read_d     = read_q;
    write_d    = write_q;
    bus_addr_d = bus_addr_q;
    wdata_d    = wdata_q;
`ifdef DBG_MEM_ACCESS_TIMEOUT_EN
    tcnt_d     = tcnt_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (take_action_ocimem_a) begin
          addr_d    = jdo[ADDR_W+1:2];
          autoinc_d = jdo[36];
          if (jdo[37]) begin
            error_d = 1'b0;
          end
          if (jdo[35]) begin
            // The read uses the address being loaded by this same command.
            state_d    = StRead;
            read_d     = 1'b1;
            ready_d    = 1'b0;
            bus_addr_d = {jdo[ADDR_W+1:2], 2'b00};
`ifdef DBG_MEM_ACCESS_TIMEOUT_EN
            tcnt_d     = '0;
`endif
          end
        end else if (take_action_ocimem_b) begin
          state_d    = StWrite;
          write_d    = 1'b1;
          ready_d    = 1'b0;
          bus_addr_d = {addr_q, 2'b00};
          wdata_d    = jdo[34:3];
`ifdef DBG_MEM_ACCESS_TIMEOUT_EN
          tcnt_d     = '0;
`endif
        end else if (take_no_action_ocimem_a) begin
          state_d    = StRead;
          read_d     = 1'b1;
          ready_d    = 1'b0;
          bus_addr_d = {addr_q, 2'b00};
`ifdef DBG_MEM_ACCESS_TIMEOUT_EN
          tcnt_d     = '0;
`endif
        end
      end

      StRead, StWrite: begin
        // Only one access may be in flight; anything arriving now is lost.
        if (any_strobe) begin
          error_d = 1'b1;
        end
        if (!avm_waitrequest) begin
          if (state_q == StRead) begin
            mon_dreg_d = avm_readdata;
          end
          read_d  = 1'b0;
          write_d = 1'b0;
          ready_d = 1'b1;
          state_d = StIdle;
          if (autoinc_q) begin
            addr_d = addr_q + ADDR_W'(1);
          end
`ifdef DBG_MEM_ACCESS_TIMEOUT_EN
        end else if (tcnt_q == TcntLast) begin
          // Abandoned access: no data capture and no address increment.
          read_d  = 1'b0;
          write_d = 1'b0;
          ready_d = 1'b1;
          error_d = 1'b1;
          state_d = StIdle;
        end else begin
          tcnt_d = tcnt_q + TcntW'(1);
`endif
        end
      end

      default: begin
        state_d = StIdle;
        read_d  = 1'b0;
        write_d = 1'b0;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      autoinc_q  <= 1'b0;
      mon_dreg_q <= '0;
      ready_q    <= 1'b1;
      error_q    <= 1'b0;
      read_q     <= 1'b0;
      write_q    <= 1'b0;
      bus_addr_q <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      autoinc_q  <= autoinc_d;
      mon_dreg_q <= mon_dreg_d;
      ready_q    <= ready_d;
      error_q    <= error_d;
      read_q     <= read_d;
      write_q    <= write_d;
      bus_addr_q <= bus_addr_d;
      wdata_q    <= wdata_d;
    end
  end

`ifdef DBG_MEM_ACCESS_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tcnt_q <= '0;
    end else begin
      tcnt_q <= tcnt_d;
    end
  end
`endif

  assign MonDReg        = mon_dreg_q;
  assign monitor_ready  = ready_q;
  assign monitor_error  = error_q;
  assign avm_address    = bus_addr_q;
  assign avm_read       = read_q;
  assign avm_write      = write_q;
  assign avm_writedata  = wdata_q;
  assign avm_byteenable = 4'hF;

endmodule

// File: tb/tb_nios_handshake_dbg_mem_access.sv
// Self-checking bench for nios_handshake_dbg_mem_access: directed table, hand-written
// multi-cycle sequences, and randomized commands checked against a transaction-level model.
// The bench plays the Avalon slave: read data is a fixed function of the byte address and
// the stall count per access is chosen by the test.

module tb_nios_handshake_dbg_mem_access;

  localparam int unsigned AW = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [37:0]   jdo;
  logic          ta_a, ta_b, tna;
  logic [31:0]   mon;
  logic          ready, err;
  logic [AW+1:0] avm_address;
  logic          avm_read, avm_write;
  logic [31:0]   avm_writedata, avm_readdata;
  logic [3:0]    avm_byteenable;
  logic          avm_waitrequest;

  nios_handshake_dbg_mem_access #(.ADDR_W(AW), .TIMEOUT_CYCLES(1023)) dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .jdo                    (jdo),
    .take_action_ocimem_a   (ta_a),
    .take_action_ocimem_b   (ta_b),
    .take_no_action_ocimem_a(tna),
    .MonDReg                (mon),
    .monitor_ready          (ready),
    .monitor_error          (err),
    .avm_address            (avm_address),
    .avm_read               (avm_read),
    .avm_write              (avm_write),
    .avm_writedata          (avm_writedata),
    .avm_byteenable         (avm_byteenable),
    .avm_readdata           (avm_readdata),
    .avm_waitrequest        (avm_waitrequest)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Slave / bus observation state, all owned by the single stimulus process.
  int          wait_cnt = 0;
  bit          force_stall = 0;
  bit          rd_fix_en = 0;
  logic [31:0] rd_fix_val = '0;
  int          n_acc = 0;
  int          last_kind = 0;  // 1 read, 2 write
  logic [17:0] last_addr = '0;
  logic [31:0] last_data = '0;
  int          rd_hi = 0;
  int          req_seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] slave_data(input logic [17:0] b);
    return 32'h5EED_0000 ^ {b[17:2], b[15:0]};
  endfunction

  function automatic logic [37:0] mk_a(input logic clr, input logic ai, input logic rd,
                                       input logic [15:0] a);
    logic [37:0] j;
    j = '0;
    j[37] = clr;
    j[36] = ai;
    j[35] = rd;
    j[17:2] = a;
    return j;
  endfunction

  function automatic logic [37:0] mk_b(input logic [31:0] d);
    logic [37:0] j;
    j = '0;
    j[34:3] = d;
    return j;
  endfunction

  // One clock: DUT samples at posedge, strobes drop right after, slave responds at negedge.
  task automatic cycle();
    @(posedge clk);
    #1;
    ta_a = 1'b0;
    ta_b = 1'b0;
    tna  = 1'b0;
    @(negedge clk);
    if (avm_read || avm_write) begin
      req_seen++;
      avm_readdata = rd_fix_en ? rd_fix_val : slave_data(avm_address);
      if (force_stall || wait_cnt > 0) begin
        avm_waitrequest = 1'b1;
        if (wait_cnt > 0) wait_cnt--;
      end else begin
        avm_waitrequest = 1'b0;
        n_acc++;
        last_kind = avm_write ? 2 : 1;
        last_addr = avm_address;
        last_data = avm_writedata;
      end
    end else begin
      avm_waitrequest = 1'b0;
    end
    if (avm_read) rd_hi++;
  endtask

  task automatic issue(input int cmd, input logic [37:0] j);
    jdo = j;
    case (cmd)
      1: ta_a = 1'b1;
      2: ta_b = 1'b1;
      default: tna = 1'b1;
    endcase
    cycle();
  endtask

  task automatic wait_ready(input int budget, input bit inject);
    int used;
    used = 0;
    while (!ready && used < budget) begin
      if (inject && used == 0 && (avm_read || avm_write)) begin
        case ($urandom_range(1, 3))
          1: ta_a = 1'b1;
          2: ta_b = 1'b1;
          default: tna = 1'b1;
        endcase
      end
      cycle();
      used++;
    end
    if (!ready) check("ready_within_budget", ready, 1'b1);
  endtask

  typedef struct {
    int          cmd;
    logic [37:0] j;
    int          waits;
    int          kind;
    logic [17:0] baddr;
    logic [31:0] wdata;
    logic [31:0] mon;
    logic        err;
  } vec_t;

  vec_t tbl[8];

  // Transaction-level model for the random phase.
  logic [15:0] m_addr;
  logic        m_ai;
  logic        m_err;
  logic [31:0] m_mon;

  initial begin
    int n0;
    reset_n = 1'b0;
    jdo = '0;
    ta_a = 1'b0;
    ta_b = 1'b0;
    tna = 1'b0;
    avm_readdata = '0;
    avm_waitrequest = 1'b0;

    tbl[0] = '{1, mk_a(0, 0, 1, 16'h0010), 2, 1, 18'h00040, 32'h0, slave_data(18'h00040), 0};
    tbl[1] = '{3, 38'h0, 0, 1, 18'h00040, 32'h0, slave_data(18'h00040), 0};
    tbl[2] = '{1, mk_a(0, 1, 0, 16'h1234), 0, 0, 18'h0, 32'h0, slave_data(18'h00040), 0};
    tbl[3] = '{2, mk_b(32'hDEADBEEF), 1, 2, 18'h048D0, 32'hDEADBEEF, slave_data(18'h00040), 0};
    tbl[4] = '{3, 38'h0, 0, 1, 18'h048D4, 32'h0, slave_data(18'h048D4), 0};
    tbl[5] = '{1, mk_a(0, 1, 1, 16'hFFFF), 3, 1, 18'h3FFFC, 32'h0, slave_data(18'h3FFFC), 0};
    tbl[6] = '{3, 38'h0, 2, 1, 18'h00000, 32'h0, slave_data(18'h00000), 0};
    tbl[7] = '{1, mk_a(1, 0, 1, 16'h0ABC), 0, 1, 18'h02AF0, 32'h0, slave_data(18'h02AF0), 0};

    // Reset values while held in reset.
    repeat (3) @(negedge clk);
    check("rst_ready", ready, 1'b1);
    check("rst_error", err, 1'b0);
    check("rst_mon", mon, 32'h0);
    check("rst_addr", avm_address, 18'h0);
    check("rst_byteen", avm_byteenable, 4'hF);
    reset_n = 1'b1;

    // Idle for 20 cycles: no bus activity.
    for (int i = 0; i < 20; i++) cycle();
    check("idle_no_req", req_seen, 0);
    check("idle_ready", ready, 1'b1);
    check("idle_error", err, 1'b0);
    check("idle_mon", mon, 32'h0);

    // Read with two wait states; address held for three cycles.
    rd_fix_en = 1;
    rd_fix_val = 32'hCAFEF00D;
    wait_cnt = 2;
    issue(1, mk_a(0, 0, 1, 16'h0010));
    for (int i = 0; i < 3; i++) begin
      check("rd2_read_held", avm_read, 1'b1);
      check("rd2_addr_held", avm_address, 18'h00040);
      check("rd2_not_ready", ready, 1'b0);
      if (i < 2) cycle();
    end
    cycle();
    check("rd2_read_drop", avm_read, 1'b0);
    check("rd2_ready", ready, 1'b1);
    check("rd2_mon", mon, 32'hCAFEF00D);
    rd_fix_en = 0;

    // Zero-wait writes across the address wrap.
    issue(1, mk_a(0, 1, 0, 16'hFFFF));
    check("wrap_load_no_req", avm_read | avm_write, 1'b0);
    check("wrap_load_ready", ready, 1'b1);
    n0 = n_acc;
    issue(2, mk_b(32'h11111111));
    check("wrap_w1_notready", ready, 1'b0);
    wait_ready(20, 0);
    check("wrap_w1_addr", last_addr, 18'h3FFFC);
    check("wrap_w1_data", last_data, 32'h11111111);
    issue(2, mk_b(32'h22222222));
    wait_ready(20, 0);
    check("wrap_w2_addr", last_addr, 18'h00000);
    check("wrap_w2_data", last_data, 32'h22222222);
    check("wrap_nacc", n_acc - n0, 2);
    check("wrap_mon_kept", mon, 32'hCAFEF00D);

    // Strobe during a stalled read is dropped and flagged; the read still completes.
    wait_cnt = 3;
    n0 = n_acc;
    issue(3, 38'h0);
    cycle();
    tna = 1'b1;
    cycle();
    check("drop_err", err, 1'b1);
    check("drop_read_held", avm_read, 1'b1);
    wait_ready(20, 0);
    check("drop_nacc", n_acc - n0, 1);
    check("drop_rd_addr", last_addr, 18'h00004);
    check("drop_mon", mon, slave_data(18'h00004));
    check("drop_err_sticky", err, 1'b1);
    issue(1, mk_a(1, 0, 0, 16'h0000));
    check("drop_err_clear", err, 1'b0);

    // Directed table.
    for (int i = 0; i < 8; i++) begin
      wait_cnt = tbl[i].waits;
      n0 = n_acc;
      issue(tbl[i].cmd, tbl[i].j);
      wait_ready(20, 0);
      check($sformatf("tbl%0d_nacc", i), n_acc - n0, (tbl[i].kind != 0) ? 1 : 0);
      if (tbl[i].kind != 0) begin
        check($sformatf("tbl%0d_kind", i), last_kind, tbl[i].kind);
        check($sformatf("tbl%0d_addr", i), last_addr, tbl[i].baddr);
      end
      if (tbl[i].kind == 2) check($sformatf("tbl%0d_wdata", i), last_data, tbl[i].wdata);
      check($sformatf("tbl%0d_mon", i), mon, tbl[i].mon);
      check($sformatf("tbl%0d_err", i), err, tbl[i].err);
    end

    // Permanent stall.
    force_stall = 1;
    rd_hi = 0;
    issue(1, mk_a(0, 1, 1, 16'h0100));
`ifdef DBG_MEM_ACCESS_TIMEOUT_EN
    wait_ready(1100, 0);
    check("to_read_cycles", rd_hi, 1023);
    check("to_read_drop", avm_read, 1'b0);
    check("to_err", err, 1'b1);
    check("to_mon_kept", mon, slave_data(18'h02AF0));
    force_stall = 0;
    issue(3, 38'h0);
    wait_ready(20, 0);
    check("to_no_inc_addr", last_addr, 18'h00400);
    issue(1, mk_a(1, 0, 0, 16'h0000));
    check("to_err_clear", err, 1'b0);
`else
    for (int i = 0; i < 1100; i++) cycle();
    check("stall_read_held", avm_read, 1'b1);
    check("stall_no_err", err, 1'b0);
    check("stall_not_ready", ready, 1'b0);
    force_stall = 0;
    wait_ready(20, 0);
    check("stall_addr", last_addr, 18'h00400);
    check("stall_mon", mon, slave_data(18'h00400));
`endif

    // Random phase: start from a known model state.
    wait_cnt = 0;
    issue(1, mk_a(1, 0, 1, 16'h0000));
    wait_ready(20, 0);
    m_addr = '0;
    m_ai = 1'b0;
    m_err = 1'b0;
    m_mon = slave_data(18'h0);
    check("rand_init_mon", mon, m_mon);
    for (int it = 0; it < 300; it++) begin
      int          cmd, kind;
      bit          inject, clr, ai, rd;
      logic [15:0] ja;
      logic [31:0] wd;
      logic [17:0] baddr;
      cmd = $urandom_range(1, 3);
      inject = ($urandom_range(0, 7) == 0);
      clr = ($urandom_range(0, 3) == 0);
      ai = $urandom_range(0, 1) != 0;
      rd = $urandom_range(0, 1) != 0;
      ja = 16'($urandom);
      wd = $urandom;
      kind = 0;
      baddr = '0;
      case (cmd)
        1: begin
          m_addr = ja;
          m_ai = ai;
          if (clr) m_err = 1'b0;
          if (rd) begin
            kind = 1;
            baddr = {ja, 2'b00};
          end
        end
        2: begin
          kind = 2;
          baddr = {m_addr, 2'b00};
        end
        default: begin
          kind = 1;
          baddr = {m_addr, 2'b00};
        end
      endcase
      if (kind == 1) m_mon = slave_data(baddr);
      if (kind != 0 && m_ai) m_addr = m_addr + 16'd1;
      if (kind != 0 && inject) m_err = 1'b1;

      wait_cnt = $urandom_range(0, 3);
      n0 = n_acc;
      issue(cmd, (cmd == 2) ? mk_b(wd) : mk_a(clr, ai, rd, ja));
      wait_ready(20, inject);
      check("rnd_nacc", n_acc - n0, (kind != 0) ? 1 : 0);
      if (kind != 0) begin
        check("rnd_kind", last_kind, kind);
        check("rnd_addr", last_addr, baddr);
      end
      if (kind == 2) check("rnd_wdata", last_data, wd);
      check("rnd_mon", mon, m_mon);
      check("rnd_err", err, m_err);
      check("rnd_ready", ready, 1'b1);
    end

    // Asynchronous reset in the middle of a stalled write.
    wait_cnt = 5;
    issue(2, mk_b(32'hA5A5A5A5));
    cycle();
    check("arst_write_before", avm_write, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_write", avm_write, 1'b0);
    check("arst_read", avm_read, 1'b0);
    check("arst_ready", ready, 1'b1);
    check("arst_error", err, 1'b0);
    check("arst_mon", mon, 32'h0);
    check("arst_addr", avm_address, 18'h0);
    check("arst_wdata", avm_writedata, 32'h0);
    wait_cnt = 0;
    @(negedge clk);
    reset_n = 1'b1;
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nios_handshake_dbg_mem_access.md
Name: nios_handshake_dbg_mem_access

Overview:
Debug memory-access engine directly downstream of the CPU debug-slave wrapper. Consumes its sysclk-domain command strobes (take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a) and the 38-bit jdo payload, then runs single-word Avalon-MM reads and writes. Returns MonDReg, monitor_ready and monitor_error to the wrapper's JTAG readback path.

Parameters:
ADDR_W, 16, word-address width; the byte address is {addr, 2'b00}
TIMEOUT_CYCLES, 1023, maximum waitrequest-stall cycles before abort (10-bit counter)

Ports:
clk  in  1  system clock; all logic on the rising edge
reset_n  in  1  asynchronous, active-low reset
jdo  in  38  command payload from the debug slave
take_action_ocimem_a  in  1  1-cycle strobe: load address / optional read
take_action_ocimem_b  in  1  1-cycle strobe: write
take_no_action_ocimem_a  in  1  1-cycle strobe: read at current address
MonDReg  out  32  last read data
monitor_ready  out  1  engine idle, last operation complete
monitor_error  out  1  sticky error: timeout or dropped command
avm_address  out  ADDR_W+2  byte address
avm_read  out  1  read request
avm_write  out  1  write request
avm_writedata  out  32  write data
avm_byteenable  out  4  constant 4'hF
avm_readdata  in  32  read data, valid when avm_read && !avm_waitrequest
avm_waitrequest  in  1  slave stall

Behaviour:
- Reset values: MonDReg=0, monitor_ready=1, monitor_error=0, avm_read=0, avm_write=0, avm_address=0, avm_writedata=0, internal addr=0, autoinc=0, FSM=IDLE.
- Reset asserted mid-transaction drops avm_read/avm_write immediately (asynchronous). No completion is reported.
- Command decode, evaluated only in IDLE. Priority is ocimem_a > ocimem_b > no_action_ocimem_a.
  - ocimem_a: addr <= jdo[ADDR_W+1:2]; autoinc <= jdo[36]; monitor_error cleared if jdo[37]=1. If jdo[35]=1, start a read, otherwise stay IDLE with no bus access.
  - ocimem_b: start a write with avm_writedata <= jdo[34:3].
  - no_action_ocimem_a: start a read.
- Strobe arriving while not IDLE: dropped; monitor_error <= 1.
- FSM states: IDLE, READ, WRITE.
  - Start: request asserted the cycle after the strobe. monitor_ready deasserted in that same cycle. avm_address={addr,2'b00}.
  - READ: hold avm_read and address until !avm_waitrequest. On that edge: MonDReg <= avm_readdata, avm_read <= 0, monitor_ready <= 1, go to IDLE.
  - WRITE: same handshake with avm_write. Completion sets monitor_ready=1 and leaves MonDReg unchanged.
  - Zero-wait slave: each access takes exactly 1 bus cycle; a strobe-to-ready latency of 2 clocks.
- Auto-increment: on successful completion with autoinc=1, addr <= addr+1, wrapping modulo 2^ADDR_W (all-ones -> 0). No increment after a timeout abort.
- Timeout (with the optional feature): counter cleared on request start, incremented each stalled cycle. When the counter reaches TIMEOUT_CYCLES:
  - drop the request;
  - monitor_error <= 1, monitor_ready <= 1;
  - go to IDLE with MonDReg unchanged.
  - If completion and the timeout fall on the same cycle, completion wins.
- Outputs are registered; there are no combinational paths from inputs to outputs.

Optional Feature:
DBG_MEM_ACCESS_TIMEOUT_EN
- Defined: the timeout counter and abort logic are present, as described above.
- Undefined: no counter; an access waits indefinitely on avm_waitrequest. monitor_error is set only by dropped commands (and cleared via jdo[37]).

Test Plan:
- Reset then idle -> monitor_ready=1, monitor_error=0, MonDReg=0, no avm_read/avm_write for 20 cycles.
- ocimem_a with jdo[ADDR_W+1:2]=16'h0010, jdo[35]=1, jdo[36]=0; slave returns 32'hCAFEF00D with 2 wait cycles -> avm_address=18'h00040 held 3 cycles; MonDReg=32'hCAFEF00D; monitor_ready high 1 cycle after the handshake.
- ocimem_a addr=16'hFFFF, autoinc=1, no read; then two ocimem_b writes with data 32'h11111111 and 32'h22222222, zero-wait -> writes land at byte address 18'h3FFFC then 18'h00000 (wrap).
- Strobe no_action_ocimem_a during a stalled read -> second strobe ignored, monitor_error=1; first read still completes normally.
- With DBG_MEM_ACCESS_TIMEOUT_EN, waitrequest held high -> avm_read drops after exactly 1023 stalled cycles; monitor_error=1, MonDReg unchanged, addr not incremented. Then ocimem_a with jdo[37]=1 -> monitor_error=0.
- Assert reset_n low mid-write -> avm_write=0 asynchronously; all outputs at reset values.
